// File: rtl/hsiao_secded_codec.sv
// hsiao_secded_codec
// -----------------------------------------------------------------------------
// Hsiao single-error-correct / double-error-detect encoder and decoder behind
// a two-stage valid/ready pipeline, with saturating SEC and DED event counters.
//
// Codeword layout: code[N-1:R] = data, code[R-1:0] = parity.
// Data bit i uses the i-th odd-weight (>= 3) R-bit vector in ascending numeric
// order as its H column. Parity bit j uses the unit vector e_j.
//
// Parameters
//   DATA_W : data width (8, 16, 32 or 64)
//   CNT_W  : width of the SEC/DED event counters
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : input beat offered
//   in_ready     : input beat accepted when in_valid && in_ready
//   in_mode      : 0 = encode, 1 = decode
//   in_data      : encode uses [DATA_W-1:0]; decode uses the whole codeword
//   out_valid    : result beat present
//   out_ready    : downstream accepts the result beat
//   out_code     : encoded or corrected codeword
//   out_data     : corrected data
//   out_syndrome : decode syndrome (0 for encode beats)
//   out_sec      : single error corrected
//   out_ded      : uncorrectable error detected
//   out_mode     : mode of the beat being presented
//   cnt_clr      : synchronous clear of both counters (wins over increments)
//   sec_cnt      : saturating count of SEC events on decode handshakes
//   ded_cnt      : saturating count of DED events on decode handshakes
// -----------------------------------------------------------------------------
module hsiao_secded_codec #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int R = (DATA_W <= 8)  ? 5 :
                       (DATA_W <= 16) ? 6 :
                       (DATA_W <= 32) ? 7 : 8,
    localparam int N = DATA_W + R
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_code,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_sec,
    output logic              out_ded,
    output logic              out_mode,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    // -------------------------------------------------------------------------
    // H matrix construction (elaboration-time only)
    // -------------------------------------------------------------------------

    // idx-th R-bit vector of odd weight >= 3, scanning values in ascending order.
    function automatic logic [R-1:0] data_col(input int idx);
        logic [R-1:0] res;
        logic [R-1:0] vec;
        int           found;
        res   = '0;
        found = 0;
        for (int v = 0; v < (1 << R); v++) begin
            vec = R'(v);
            if (($countones(vec) >= 3) && (($countones(vec) % 2) == 1)) begin
                if (found == idx) begin
                    res = vec;
                end
                found++;
            end
        end
        return res;
    endfunction

    // Column of codeword bit k: unit vectors for parity, odd-weight for data.
    function automatic logic [R-1:0] code_col(input int k);
        logic [R-1:0] res;
        if (k < R) begin
            res = R'(1) << k;
        end else begin
            res = data_col(k - R);
        end
        return res;
    endfunction

    // Row j of the data part of H: which data bits feed parity bit j.
    function automatic logic [DATA_W-1:0] row_mask(input int j);
        logic [DATA_W-1:0] m;
        logic [R-1:0]      c;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c    = data_col(i);
            m[i] = c[j];
        end
        return m;
    endfunction

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic              s1_valid_reg;
    logic              s1_mode_reg;
    logic [N-1:0]      s1_code_reg;
    logic [R-1:0]      s1_syn_reg;

    logic              s2_valid_reg;
    logic              s2_mode_reg;
    logic [N-1:0]      s2_code_reg;
    logic [R-1:0]      s2_syn_reg;
    logic              s2_sec_reg;
    logic              s2_ded_reg;

    logic [CNT_W-1:0]  sec_cnt_reg;
    logic [CNT_W-1:0]  ded_cnt_reg;

    logic              s1_advance;
    logic              s2_advance;
    logic              out_hs;

    // -------------------------------------------------------------------------
    // Stage 1 combinational: parity generation and syndrome
    // -------------------------------------------------------------------------
    logic [R-1:0]      enc_parity;   // parity of in_data[DATA_W-1:0] (encode)
    logic [R-1:0]      rx_parity;    // parity recomputed from received data
    logic [N-1:0]      s1_code_next;
    logic [R-1:0]      s1_syn_next;

    for (genvar gi = 0; gi < R; gi++) begin : g_parity
        localparam logic [DATA_W-1:0] ROW = row_mask(gi);
        assign enc_parity[gi] = ^(in_data[DATA_W-1:0] & ROW);
        assign rx_parity[gi]  = ^(in_data[N-1:R] & ROW);
    end

    always_comb begin
        s1_code_next = {in_data[DATA_W-1:0], enc_parity};
        s1_syn_next  = '0;
        if (in_mode) begin
            s1_code_next = in_data;
            s1_syn_next  = rx_parity ^ in_data[R-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational: column match and correction
    // -------------------------------------------------------------------------
    // No column is zero and all columns are distinct, so at most one flip bit
    // is set, and none for a zero syndrome. A nonzero syndrome with no match is
    // exactly the uncorrectable case, which leaves the codeword untouched.
    logic [N-1:0]      flip;
    logic              s2_sec_next;
    logic              s2_ded_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_match
        localparam logic [R-1:0] COL = code_col(gi);
        assign flip[gi] = (s1_syn_reg == COL);
    end

    assign s2_sec_next = |flip;
    assign s2_ded_next = (s1_syn_reg != '0) && !s2_sec_next;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A stage moves when it is empty or the stage after it is empty/draining.
    assign s2_advance = !s2_valid_reg || out_ready;
    assign s1_advance = s2_advance;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign out_hs     = s2_valid_reg && out_ready;

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_code_reg  <= '0;
            s1_syn_reg   <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            // Payload only captured on acceptance so idle cycles do not disturb it.
            if (in_valid) begin
                s1_mode_reg <= in_mode;
                s1_code_reg <= s1_code_next;
                s1_syn_reg  <= s1_syn_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 (output) registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= 1'b0;
            s2_code_reg  <= '0;
            s2_syn_reg   <= '0;
            s2_sec_reg   <= 1'b0;
            s2_ded_reg   <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mode_reg <= s1_mode_reg;
                s2_code_reg <= s1_code_reg ^ flip;
                s2_syn_reg  <= s1_syn_reg;
                s2_sec_reg  <= s2_sec_next;
                s2_ded_reg  <= s2_ded_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_reg <= '0;
            ded_cnt_reg <= '0;
        end else if (cnt_clr) begin
            sec_cnt_reg <= '0;
            ded_cnt_reg <= '0;
        end else if (out_hs && s2_mode_reg) begin
            if (s2_sec_reg && (sec_cnt_reg != '1)) begin
                sec_cnt_reg <= sec_cnt_reg + CNT_W'(1);
            end
            if (s2_ded_reg && (ded_cnt_reg != '1)) begin
                ded_cnt_reg <= ded_cnt_reg + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid    = s2_valid_reg;
    assign out_code     = s2_code_reg;
    assign out_data     = s2_code_reg[N-1:R];
    assign out_syndrome = s2_syn_reg;
    assign out_sec      = s2_sec_reg;
    assign out_ded      = s2_ded_reg;
    assign out_mode     = s2_mode_reg;
    assign sec_cnt      = sec_cnt_reg;
    assign ded_cnt      = ded_cnt_reg;

endmodule

// File: tb/tb_hsiao_secded_codec.sv
// tb_hsiao_secded_codec
// Directed and randomized bench for hsiao_secded_codec at DATA_W = 8 (R = 5,
// N = 13). CNT_W is reduced to 4 so counter saturation is reachable quickly.
// Expected results come from a reference model that forms the syndrome as the
// XOR of the H columns of every set codeword bit and locates a single error by
// searching the column list.
module tb_hsiao_secded_codec;

    localparam int DW   = 8;
    localparam int R    = 5;
    localparam int N    = 13;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_code;
    logic [DW-1:0] out_data;
    logic [R-1:0]  out_syndrome;
    logic          out_sec;
    logic          out_ded;
    logic          out_mode;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] sec_cnt;
    logic [CW-1:0] ded_cnt;

    hsiao_secded_codec #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .out_mode     (out_mode),
        .cnt_clr      (cnt_clr),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  code;
        logic [DW-1:0] data;
        logic [R-1:0]  syn;
        logic          sec;
        logic          ded;
        logic          mode;
    } beat_t;

    beat_t        q[$];
    logic [R-1:0] dcol [DW];
    int           tests = 0;
    int           fails = 0;
    int           m_sec = 0;
    int           m_ded = 0;

    bit           acc_seen, hs_seen, ir_seen;
    logic [N-1:0] last_code;
    logic [DW-1:0] last_data;
    logic [R-1:0] last_syn;
    logic         last_sec, last_ded;
    bit           held = 0;
    logic [N-1:0] h_code;
    logic [R-1:0] h_syn;
    logic         h_sec, h_ded, h_mode;

    // ------------------------------------------------------------------ model
    function automatic logic [R-1:0] hcol(input int k);
        if (k < R) return 5'd1 << k;
        return dcol[k - R];
    endfunction

    function automatic beat_t model(input logic mode, input logic [N-1:0] din);
        beat_t        b;
        logic [N-1:0] cw;
        logic [R-1:0] par;
        logic [R-1:0] syn;
        int           pos;
        syn = '0;
        if (!mode) begin
            par = '0;
            for (int i = 0; i < DW; i++) if (din[i]) par ^= dcol[i];
            cw = {din[DW-1:0], par};
        end else begin
            cw = din;
            for (int k = 0; k < N; k++) if (cw[k]) syn ^= hcol(k);
        end
        pos = -1;
        if (syn != '0)
            for (int k = 0; k < N; k++) if (hcol(k) == syn) pos = k;
        b.sec  = (pos >= 0);
        b.ded  = (syn != '0) && (pos < 0);
        b.code = b.sec ? (cw ^ (13'd1 << pos)) : cw;
        b.data = b.code[N-1:R];
        b.syn  = syn;
        b.mode = mode;
        return b;
    endfunction

    // ----------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock cycle: observe at the falling edge, then move past the rising edge.
    task automatic cycle();
        beat_t e;
        bit    popped;
        popped = 0;
        @(negedge clk);
        check("sec_cnt", sec_cnt, m_sec);
        check("ded_cnt", ded_cnt, m_ded);
        if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_code", out_code, h_code);
            check("hold_syn", out_syndrome, h_syn);
            check("hold_flags", {out_sec, out_ded, out_mode}, {h_sec, h_ded, h_mode});
        end
        ir_seen  = in_ready;
        acc_seen = rst_n && in_valid && in_ready;
        hs_seen  = rst_n && out_valid && out_ready;
        if (hs_seen) begin
            check("beat_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                popped = 1;
                check("out_code", out_code, e.code);
                check("out_data", out_data, e.data);
                check("out_syn", out_syndrome, e.syn);
                check("out_sec", out_sec, e.sec);
                check("out_ded", out_ded, e.ded);
                check("out_mode", out_mode, e.mode);
            end
            last_code = out_code; last_data = out_data; last_syn = out_syndrome;
            last_sec  = out_sec;  last_ded  = out_ded;
        end
        if (cnt_clr) begin
            m_sec = 0; m_ded = 0;
        end else if (popped && e.mode) begin
            if (e.sec && m_sec < CMAX) m_sec++;
            if (e.ded && m_ded < CMAX) m_ded++;
        end
        if (acc_seen) q.push_back(model(in_mode, in_data));
        held   = rst_n && out_valid && !out_ready;
        h_code = out_code; h_syn = out_syndrome;
        h_sec  = out_sec;  h_ded = out_ded; h_mode = out_mode;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [N-1:0] d);
        in_valid = 1'b1; in_mode = mode; in_data = d;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (acc_seen) break;
        end
        check("send_accepted", acc_seen, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (hs_seen) break;
        end
        check("out_timeout", hs_seen, 1);
    endtask

    function automatic logic [N-1:0] rand_code();
        logic [N-1:0] cw;
        int           nf;
        cw = model(1'b0, {5'b0, DW'($urandom)}).code;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) cw[$urandom_range(0, N - 1)] ^= 1'b1;
        return cw;
    endfunction

    // --------------------------------------------------------------- stimulus
    initial begin
        int n;
        int hs_n;
        int acc_n;
        logic [N-1:0] cw;

        n = 0;
        for (int v = 0; v < 32; v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1 && n < DW) begin
                dcol[n] = 5'(v);
                n++;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_flags", {out_sec, out_ded, out_mode, out_syndrome}, 0);
        check("rst_sec_cnt", sec_cnt, 0);
        check("rst_ded_cnt", ded_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Encode 0x01 with exact two-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 13'h001;
        cycle();
        check("enc_accept", acc_seen, 1);
        in_valid = 1'b0;
        cycle();
        check("lat_not_early", hs_seen, 0);
        cycle();
        check("lat_two", hs_seen, 1);
        check("enc01_code", last_code, 13'h027);
        check("enc01_flags", {last_sec, last_ded}, 2'b00);

        // Decode with data bit 0 flipped
        send(1'b1, 13'h007);
        wait_out();
        check("sec_syn", last_syn, 5'b00111);
        check("sec_data", last_data, 8'h01);
        check("sec_code", last_code, 13'h027);
        check("sec_flag", last_sec, 1);
        check("sec_cnt_1", sec_cnt, 1);

        // Decode with two parity bits flipped
        send(1'b1, 13'h024);
        wait_out();
        check("ded_syn", last_syn, 5'b00011);
        check("ded_flag", last_ded, 1);
        check("ded_code", last_code, 13'h024);
        check("ded_cnt_1", ded_cnt, 1);

        // Backpressure: three beats offered, two accepted
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 13'(8'h3C);
        cycle(); check("bp_acc_a", acc_seen, 1);
        in_data = 13'(8'hA5);
        cycle(); check("bp_acc_b", acc_seen, 1);
        in_data = rand_code(); in_mode = 1'b1;
        cycle(); check("bp_acc_c", acc_seen, 0);
        check("bp_in_ready_low", ir_seen, 0);
        cycle(); cycle();
        out_ready = 1'b1;
        hs_n = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (hs_seen) hs_n++;
            if (acc_seen) in_valid = 1'b0;
        end
        check("bp_one_per_cycle", hs_n, 3);
        check("bp_queue_empty", q.size(), 0);

        // Counter clear racing a SEC handshake
        out_ready = 1'b0;
        send(1'b1, 13'h007);
        for (int i = 0; i < 10 && !out_valid; i++) cycle();
        cnt_clr = 1'b1; out_ready = 1'b1;
        cycle();
        check("clr_hs", hs_seen, 1);
        cnt_clr = 1'b0;
        check("clr_priority", sec_cnt, 0);

        // Saturation: more SEC beats than the counter can hold
        acc_n = 0;
        in_mode = 1'b1;
        for (int i = 0; i < 60 && acc_n < CMAX + 5; i++) begin
            cw = model(1'b0, {5'b0, DW'($urandom)}).code;
            cw[$urandom_range(0, N - 1)] ^= 1'b1;
            in_valid = 1'b1; in_data = cw;
            cycle();
            if (acc_seen) acc_n++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
        cycle();
        check("sat_max", sec_cnt, CMAX);
        send(1'b1, 13'h007);
        wait_out();
        cycle();
        check("sat_stays", sec_cnt, CMAX);

        // Randomized traffic with random stalls and occasional clears
        for (int i = 0; i < 400; i++) begin
            if (!in_valid && ($urandom % 4) != 0) begin
                in_valid = 1'b1;
                in_mode  = 1'($urandom);
                in_data  = in_mode ? rand_code() : N'($urandom);
            end
            out_ready = (($urandom % 4) != 0);
            cnt_clr   = (($urandom % 40) == 0);
            cycle();
            if (acc_seen) in_valid = 1'b0;
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        check("rand_drained", q.size(), 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b1, 13'h007);
        send(1'b1, 13'h024);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sec_cnt", sec_cnt, 0);
        check("mid_rst_ded_cnt", ded_cnt, 0);
        q.delete();
        m_sec = 0; m_ded = 0; held = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (hs_seen) n++;
        end
        check("mid_rst_no_output", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
